cvp14_ram_bist: RTL and testbench

//  Bus-initiator memory self-test engine for the CVP14 memory interface; drives the staticram port (Addr/RD/WR/data).

---
 rtl/cvp14_bist_pkg.sv | 29 ++
 rtl/cvp14_bist_rd_pipe.sv | 50 +++++
 rtl/cvp14_ram_bist.sv | 248 ++++++++++++++++++++++++
 tb/tb_cvp14_ram_bist.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cvp14_bist_pkg.sv
// ----------------------------------------------------------------------------
// cvp14_bist_pkg
//   Shared definitions for the CVP14 RAM self-test engine:
//     - bist_state_t      : FSM state encoding (also exported on dbg_state)
//     - BIST_DEFAULT_SEED : default pattern seed
//     - bist_pattern()    : test data for an address, optionally inverted
// ----------------------------------------------------------------------------
package cvp14_bist_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_READ  = 3'd2,
        ST_WAIT  = 3'd3,
        ST_DONE  = 3'd4
    } bist_state_t;

    localparam logic [15:0] BIST_DEFAULT_SEED = 16'hA5A5;

    // Computed at 32 bits; callers cast the result down to their data width.
    function automatic logic [31:0] bist_pattern(input logic [31:0] addr,
                                                 input logic [31:0] seed,
                                                 input logic        invert);
        logic [31:0] p;
        p = addr ^ seed;
        return invert ? ~p : p;
    endfunction

endpackage

// File: rtl/cvp14_bist_rd_pipe.sv
// ----------------------------------------------------------------------------
// cvp14_bist_rd_pipe
//   LATENCY-deep shift register carrying the read-valid flag and the read
//   address. A read issued in cycle t appears on out_valid/out_addr in cycle
//   t+LATENCY, which is the cycle in which DataIn is valid and sampled.
// Ports
//   clk       in   clock, rising edge
//   rst       in   synchronous active-high reset
//   flush     in   synchronous clear of all in-flight valid flags
//   in_valid  in   read strobe issued this cycle
//   in_addr   in   address of that read
//   out_valid out  delayed read strobe
//   out_addr  out  delayed read address
// ----------------------------------------------------------------------------
module cvp14_bist_rd_pipe #(
    parameter int ADDR_W  = 16,
    parameter int LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [ADDR_W-1:0] in_addr,
    output logic              out_valid,
    output logic [ADDR_W-1:0] out_addr
);

    logic [LATENCY-1:0] valid_sr;
    logic [ADDR_W-1:0]  addr_sr [LATENCY];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            valid_sr <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                addr_sr[i] <= '0;
            end
        end else begin
            valid_sr[0] <= in_valid;
            addr_sr[0]  <= in_addr;
            for (int i = 1; i < LATENCY; i++) begin
                valid_sr[i] <= valid_sr[i-1];
                addr_sr[i]  <= addr_sr[i-1];
            end
        end
    end

    assign out_valid = valid_sr[LATENCY-1];
    assign out_addr  = addr_sr[LATENCY-1];

endmodule

// File: rtl/cvp14_ram_bist.sv
// ----------------------------------------------------------------------------
// cvp14_ram_bist
//   Bus-initiating RAM self-test. Writes pattern(a) = a ^ SEED to every
//   address of [StartAddr, EndAddr], then reads each back and compares.
//   Stops at the first mismatch and reports its address and read data.
//
// Optional feature (macro BIST_INVERT_PASS_EN):
//   After a clean pass 0, a second write+read pass runs with ~(a ^ SEED);
//   a failure there reports FailPass=1. Without the macro FailPass is 0.
//
// Control protocol: Start is a one-cycle request accepted only when the
//   engine is idle (IDLE or DONE); Done is a level held until the next
//   accepted Start, Abort or Reset, and Fail/FailAddr/FailData/FailPass are
//   meaningful only while Done=1. Abort has priority over Start.
//
// Ports
//   Clk1       in   clock, rising edge
//   Reset      in   synchronous active-high reset
//   Start      in   begin test (ignored while Busy)
//   Abort      in   stop test, return to IDLE
//   StartAddr  in   first address (latched on Start)
//   EndAddr    in   last address, inclusive (latched on Start)
//   Addr       out  RAM address
//   RD / WR    out  RAM read / write strobes (never both high)
//   DataOut    out  RAM write data
//   DataIn     in   RAM read data, valid RD_LATENCY cycles after RD
//   Busy       out  test in progress
//   Done       out  test finished
//   Fail       out  mismatch found
//   FailAddr   out  address of first mismatch
//   FailData   out  data read at FailAddr
//   FailPass   out  pass in which the mismatch occurred
//   dbg_state  out  current FSM state (bist_state_t encoding)
// ----------------------------------------------------------------------------
module cvp14_ram_bist
    import cvp14_bist_pkg::*;
#(
    parameter int                ADDR_W     = 16,
    parameter int                DATA_W     = 16,
    parameter int                RD_LATENCY = 1,
    parameter logic [DATA_W-1:0] SEED       = DATA_W'(BIST_DEFAULT_SEED)
) (
    input  logic              Clk1,
    input  logic              Reset,
    input  logic              Start,
    input  logic              Abort,
    input  logic [ADDR_W-1:0] StartAddr,
    input  logic [ADDR_W-1:0] EndAddr,
    output logic [ADDR_W-1:0] Addr,
    output logic              RD,
    output logic              WR,
    output logic [DATA_W-1:0] DataOut,
    input  logic [DATA_W-1:0] DataIn,
    output logic              Busy,
    output logic              Done,
    output logic              Fail,
    output logic [ADDR_W-1:0] FailAddr,
    output logic [DATA_W-1:0] FailData,
    output logic              FailPass,
    output logic [2:0]        dbg_state
);

    bist_state_t       state, state_n;
    logic [ADDR_W-1:0] cur, cur_n;
    logic [ADDR_W-1:0] start_q, end_q;
    logic              pass_q, pass_n;
    logic [DATA_W-1:0] dout_q;
    logic [DATA_W-1:0] exp_data;
    logic              load_range;
    logic              clear_fail;
    logic              set_fail;
    logic              flush;
    logic              pipe_valid;
    logic [ADDR_W-1:0] pipe_addr;

    // Read-valid/address pipe: tells the FSM which cycle holds the data.
    cvp14_bist_rd_pipe #(
        .ADDR_W  (ADDR_W),
        .LATENCY (RD_LATENCY)
    ) u_rd_pipe (
        .clk       (Clk1),
        .rst       (Reset),
        .flush     (flush),
        .in_valid  (RD),
        .in_addr   (cur),
        .out_valid (pipe_valid),
        .out_addr  (pipe_addr)
    );

    assign exp_data = DATA_W'(bist_pattern(32'(pipe_addr), 32'(SEED), pass_q));

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_n    = state;
        cur_n      = cur;
        load_range = 1'b0;
        clear_fail = 1'b0;
        set_fail   = 1'b0;
        flush      = 1'b0;
`ifdef BIST_INVERT_PASS_EN
        pass_n     = pass_q;
`endif

        unique case (state)
            ST_IDLE, ST_DONE: begin
                if (Start) begin
                    load_range = 1'b1;
                    clear_fail = 1'b1;
                    flush      = 1'b1;
                    cur_n      = StartAddr;
`ifdef BIST_INVERT_PASS_EN
                    pass_n     = 1'b0;
`endif
                    // Empty range completes at once without touching the bus.
                    state_n    = (EndAddr < StartAddr) ? ST_DONE : ST_WRITE;
                end
            end

            ST_WRITE: begin
                // Equality test only: an EndAddr of all-ones must not wrap.
                if (cur == end_q) begin
                    cur_n   = start_q;
                    state_n = ST_READ;
                end else begin
                    cur_n   = cur + ADDR_W'(1);
                end
            end

            ST_READ: begin
                state_n = ST_WAIT;
            end

            ST_WAIT: begin
                if (pipe_valid) begin
                    if (DataIn != exp_data) begin
                        set_fail = 1'b1;
                        state_n  = ST_DONE;
                    end else if (pipe_addr == end_q) begin
`ifdef BIST_INVERT_PASS_EN
                        if (!pass_q) begin
                            pass_n  = 1'b1;
                            cur_n   = start_q;
                            state_n = ST_WRITE;
                        end else begin
                            state_n = ST_DONE;
                        end
`else
                        state_n = ST_DONE;
`endif
                    end else begin
                        cur_n   = pipe_addr + ADDR_W'(1);
                        state_n = ST_READ;
                    end
                end
            end

            default: begin
                state_n = ST_IDLE;
            end
        endcase

        // Abort overrides everything above, including a same-cycle Start.
        if (Abort) begin
            state_n    = ST_IDLE;
            cur_n      = cur;
            load_range = 1'b0;
            set_fail   = 1'b0;
            clear_fail = 1'b1;
            flush      = 1'b1;
`ifdef BIST_INVERT_PASS_EN
            pass_n     = 1'b0;
`endif
        end
    end

`ifndef BIST_INVERT_PASS_EN
    assign pass_q = 1'b0;
    assign pass_n = 1'b0;
`endif

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge Clk1) begin
        if (Reset) begin
            state   <= ST_IDLE;
            cur     <= '0;
            start_q <= '0;
            end_q   <= '0;
            dout_q  <= '0;
`ifdef BIST_INVERT_PASS_EN
            pass_q  <= 1'b0;
`endif
        end else begin
            state <= state_n;
            cur   <= cur_n;
`ifdef BIST_INVERT_PASS_EN
            pass_q <= pass_n;
`endif
            if (load_range) begin
                start_q <= StartAddr;
                end_q   <= EndAddr;
            end
            // Write data is prepared one cycle ahead so it is registered
            // in the WR cycle, and otherwise holds its last value.
            if (state_n == ST_WRITE) begin
                dout_q <= DATA_W'(bist_pattern(32'(cur_n), 32'(SEED), pass_n));
            end
        end
    end

    // First-failure capture.
    always_ff @(posedge Clk1) begin
        if (Reset || clear_fail) begin
            Fail     <= 1'b0;
            FailAddr <= '0;
            FailData <= '0;
`ifdef BIST_INVERT_PASS_EN
            FailPass <= 1'b0;
`endif
        end else if (set_fail) begin
            Fail     <= 1'b1;
            FailAddr <= pipe_addr;
            FailData <= DataIn;
`ifdef BIST_INVERT_PASS_EN
            FailPass <= pass_q;
`endif
        end
    end

`ifndef BIST_INVERT_PASS_EN
    assign FailPass = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign Addr      = cur;
    assign DataOut   = dout_q;
    assign WR        = (state == ST_WRITE);
    assign RD        = (state == ST_READ);
    assign Busy      = (state == ST_WRITE) || (state == ST_READ) || (state == ST_WAIT);
    assign Done      = (state == ST_DONE);
    assign dbg_state = state;

endmodule

// File: tb/tb_cvp14_ram_bist.sv
module tb_cvp14_ram_bist;

    localparam logic [15:0] SEED = 16'hA5A5;
`ifdef BIST_INVERT_PASS_EN
    localparam int NPASS = 2;
`else
    localparam int NPASS = 1;
`endif

    logic        Clk1;
    logic        Reset;
    logic        Start;
    logic        Abort;
    logic [15:0] StartAddr;
    logic [15:0] EndAddr;
    logic [15:0] Addr;
    logic        RD;
    logic        WR;
    logic [15:0] DataOut;
    logic [15:0] DataIn;
    logic        Busy;
    logic        Done;
    logic        Fail;
    logic [15:0] FailAddr;
    logic [15:0] FailData;
    logic        FailPass;
    logic [2:0]  dbg_state;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] wr_exp_q[$];
    logic [15:0] rd_exp_q[$];

    logic [15:0] fault_addr = 16'h0000;
    logic [15:0] fault_mask = 16'h0000;
    logic [15:0] mem [0:65535];
    logic [15:0] ram_q = 16'h0000;

    cvp14_ram_bist dut (
        .Clk1      (Clk1),
        .Reset     (Reset),
        .Start     (Start),
        .Abort     (Abort),
        .StartAddr (StartAddr),
        .EndAddr   (EndAddr),
        .Addr      (Addr),
        .RD        (RD),
        .WR        (WR),
        .DataOut   (DataOut),
        .DataIn    (DataIn),
        .Busy      (Busy),
        .Done      (Done),
        .Fail      (Fail),
        .FailAddr  (FailAddr),
        .FailData  (FailData),
        .FailPass  (FailPass),
        .dbg_state (dbg_state)
    );

    // ---------------- clock ----------------
    initial Clk1 = 1'b0;
    always #5 Clk1 = ~Clk1;

    // ---------------- reference helpers ----------------
    function automatic logic [15:0] pat(input logic [15:0] a, input int p);
        return (p != 0) ? ~(a ^ SEED) : (a ^ SEED);
    endfunction

    // Stuck-at-0 fault on the bits of fault_mask at fault_addr.
    function automatic logic [15:0] ram_rd(input logic [15:0] a, input logic [15:0] d);
        return (a == fault_addr) ? (d & ~fault_mask) : d;
    endfunction

    // ---------------- RAM model, read latency 1 ----------------
    always @(posedge Clk1) begin
        if (WR) mem[Addr] <= DataOut;
        if (RD) ram_q <= ram_rd(Addr, mem[Addr]);
    end
    assign DataIn = ram_q;

    // ---------------- check / scoreboard ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge Clk1) begin
        if (RD || WR) chk("rd_wr_exclusive", 64'(RD & WR), 64'd0);
        if (WR) begin
            if (wr_exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_wr: got addr 0x%0h data 0x%0h, expected no write", Addr, DataOut);
            end else begin
                chk("wr_beat", 64'({Addr, DataOut}), 64'(wr_exp_q.pop_front()));
            end
        end
        if (RD) begin
            if (rd_exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_rd: got addr 0x%0h, expected no read", Addr);
            end else begin
                chk("rd_beat", 64'(Addr), 64'(rd_exp_q.pop_front()));
            end
        end
    end

    // Expected bus traffic for a run over [s,e] against the faulty RAM model.
    task automatic push_expect(input logic [15:0] s, input logic [15:0] e);
        bit failed;
        failed = 1'b0;
        if (e < s) return;
        for (int p = 0; p < NPASS && !failed; p++) begin
            for (int a = int'(s); a <= int'(e); a++)
                wr_exp_q.push_back({16'(a), pat(16'(a), p)});
            for (int a = int'(s); a <= int'(e) && !failed; a++) begin
                rd_exp_q.push_back(16'(a));
                if (ram_rd(16'(a), pat(16'(a), p)) != pat(16'(a), p)) failed = 1'b1;
            end
        end
    endtask

    task automatic chk_queues(input string name);
        chk({name, "_wr_left"}, 64'(wr_exp_q.size()), 64'd0);
        chk({name, "_rd_left"}, 64'(rd_exp_q.size()), 64'd0);
        wr_exp_q.delete();
        rd_exp_q.delete();
    endtask

    // Called at a negedge (cycle 0); returns at the negedge of cycle 1.
    task automatic start_pulse(input logic [15:0] s, input logic [15:0] e);
        StartAddr = s;
        EndAddr   = e;
        Start     = 1'b1;
        @(negedge Clk1);
        Start     = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int cnt;
        cnt = 0;
        while (!Done && cnt < 2000) begin
            @(negedge Clk1);
            cnt++;
        end
        chk({name, "_done"}, 64'(Done), 64'd1);
        if (!Done) begin
            Abort = 1'b1;
            @(negedge Clk1);
            Abort = 1'b0;
        end
    endtask

    typedef struct {
        logic [15:0] s;
        logic [15:0] e;
        logic [15:0] faddr;
        logic [15:0] fmask;
        logic        exp_fail;
        logic [15:0] exp_faddr;
        logic [15:0] exp_fdata;
        string       name;
    } vec_t;

    vec_t vecs[7];

    task automatic run_vec(input vec_t v);
        fault_addr = v.faddr;
        fault_mask = v.fmask;
        push_expect(v.s, v.e);
        start_pulse(v.s, v.e);
        wait_done(v.name);
        chk({v.name, "_fail"},      64'(Fail),     64'(v.exp_fail));
        chk({v.name, "_fail_addr"}, 64'(FailAddr), 64'(v.exp_faddr));
        chk({v.name, "_fail_data"}, 64'(FailData), 64'(v.exp_fdata));
        chk({v.name, "_fail_pass"}, 64'(FailPass), 64'd0);
        chk({v.name, "_busy"},      64'(Busy),     64'd0);
        chk_queues(v.name);
        @(negedge Clk1);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [15:0] rs;
        logic [15:0] re;
        vec_t        rv;

        vecs[0] = '{16'h0010, 16'h0013, 16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h0000, "good_10_13"};
        vecs[1] = '{16'h0010, 16'h0013, 16'h0012, 16'h0001, 1'b1, 16'h0012, 16'hA5B6, "stuck_0012"};
        vecs[2] = '{16'h0020, 16'h001F, 16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h0000, "empty_range"};
        vecs[3] = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h0000, "top_of_map"};
        vecs[4] = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h0000, "single_0000"};
        vecs[5] = '{16'h0100, 16'h0107, 16'h0106, 16'h0001, 1'b1, 16'h0106, 16'hA4A2, "stuck_0106"};
        vecs[6] = '{16'h1234, 16'h1236, 16'h1235, 16'h8000, 1'b1, 16'h1235, 16'h3790, "stuck_1235_b15"};

        Reset = 1'b1;
        Start = 1'b0;
        Abort = 1'b0;
        StartAddr = 16'h0000;
        EndAddr   = 16'h0000;

        // Reset state
        repeat (3) @(negedge Clk1);
        chk("reset_ctl", 64'({RD, WR, Busy, Done, Fail, FailPass, dbg_state}), 64'd0);
        chk("reset_bus", 64'({Addr, DataOut, FailAddr, FailData}), 64'd0);
        Reset = 1'b0;
        @(negedge Clk1);
        chk("idle_ctl", 64'({RD, WR, Busy, Done}), 64'd0);

        // Cycle-exact timing of a 4-address run
        fault_addr = 16'h0000;
        fault_mask = 16'h0000;
        push_expect(16'h0010, 16'h0013);
        start_pulse(16'h0010, 16'h0013);
        for (int k = 1; k <= 12; k++) begin
            chk($sformatf("timing_wr_c%0d", k), 64'(WR), 64'(k <= 4));
            chk($sformatf("timing_rd_c%0d", k), 64'(RD), 64'(k == 5 || k == 7 || k == 9 || k == 11));
            chk($sformatf("timing_busy_c%0d", k), 64'(Busy), 64'd1);
            @(negedge Clk1);
        end
`ifdef BIST_INVERT_PASS_EN
        chk("timing_pass1_wr_c13", 64'(WR), 64'd1);
`else
        chk("timing_done_c13", 64'({Done, Fail}), 64'b10);
`endif
        wait_done("timing");
        chk("timing_fail", 64'(Fail), 64'd0);
        chk_queues("timing");
        @(negedge Clk1);

        // Table-driven vectors
        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        // Empty range: Done already in the cycle after Start
        start_pulse(16'h0020, 16'h001F);
        chk("empty_done_c1", 64'({Done, Busy, Fail}), 64'b100);
        chk_queues("empty_hand");
        @(negedge Clk1);

        // Random short ranges on a good RAM
        for (int i = 0; i < 3; i++) begin
            rs = 16'($urandom_range(0, 16'hFFF0));
            re = rs + 16'($urandom_range(0, 6));
            rv = '{rs, re, 16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h0000, $sformatf("rand%0d", i)};
            run_vec(rv);
        end

        // Fault visible only on inverted data (bit0 is 0 in pass-0 pattern A5B4)
        fault_addr = 16'h0011;
        fault_mask = 16'h0001;
        push_expect(16'h0010, 16'h0013);
        start_pulse(16'h0010, 16'h0013);
        wait_done("inv_only");
`ifdef BIST_INVERT_PASS_EN
        chk("inv_only_fail", 64'({Fail, FailPass}), 64'b11);
        chk("inv_only_addr", 64'(FailAddr), 64'h0011);
        chk("inv_only_data", 64'(FailData), 64'h5A4A);
`else
        chk("inv_only_fail", 64'({Fail, FailPass}), 64'b00);
`endif
        chk_queues("inv_only");
        fault_mask = 16'h0000;
        @(negedge Clk1);

        // Abort in the first WAIT cycle (cycle 6)
        wr_exp_q.push_back({16'h0010, 16'hA5B5});
        wr_exp_q.push_back({16'h0011, 16'hA5B4});
        wr_exp_q.push_back({16'h0012, 16'hA5B7});
        wr_exp_q.push_back({16'h0013, 16'hA5B6});
        rd_exp_q.push_back(16'h0010);
        start_pulse(16'h0010, 16'h0013);
        repeat (5) @(negedge Clk1);
        chk("abort_in_wait_state", 64'(dbg_state), 64'd3);
        Abort = 1'b1;
        @(negedge Clk1);
        Abort = 1'b0;
        chk("abort_ctl", 64'({RD, WR, Busy, Done}), 64'd0);
        chk("abort_state", 64'(dbg_state), 64'd0);
        repeat (3) @(negedge Clk1);
        chk("abort_quiet", 64'({RD, WR, Busy, Done}), 64'd0);
        chk_queues("abort");

        // Abort and Start together: Abort wins
        StartAddr = 16'h0010;
        EndAddr   = 16'h0013;
        Start = 1'b1;
        Abort = 1'b1;
        @(negedge Clk1);
        Start = 1'b0;
        Abort = 1'b0;
        chk("abort_vs_start", 64'({RD, WR, Busy, Done}), 64'd0);
        @(negedge Clk1);
        chk_queues("abort_vs_start");

        // Reset in the second WRITE cycle
        wr_exp_q.push_back({16'h0010, 16'hA5B5});
        wr_exp_q.push_back({16'h0011, 16'hA5B4});
        start_pulse(16'h0010, 16'h0013);
        @(negedge Clk1);
        Reset = 1'b1;
        @(negedge Clk1);
        Reset = 1'b0;
        chk("reset_mid_ctl", 64'({RD, WR, Busy, Done, Fail}), 64'd0);
        chk("reset_mid_bus", 64'({Addr, DataOut}), 64'd0);
        chk_queues("reset_mid");

        // Fresh run after abort/reset
        run_vec(vecs[0]);
        run_vec(vecs[1]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
